// File: rtl/sprite_palette_pkg.sv
// Shared types and the default colour table for the sprite palette lookup.
package sprite_palette_pkg;

  // Geometry of the built-in default table.
  localparam int unsigned DEF_COLOR_W = 4;
  localparam int unsigned DEF_IDX_W   = 4;
  localparam int unsigned DEF_ENTRIES = 16;

  typedef struct packed {
    logic [DEF_COLOR_W-1:0] r;
    logic [DEF_COLOR_W-1:0] g;
    logic [DEF_COLOR_W-1:0] b;
  } rgb_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } pal_state_e;

  // {R,G,B} nibbles, loaded into every bank after reset.
  localparam logic [3*DEF_COLOR_W-1:0] DEFAULT_PALETTE [DEF_ENTRIES] = '{
    12'h000, 12'hFFF, 12'hF00, 12'h630,
    12'h0F0, 12'h00F, 12'h084, 12'hFF0,
    12'h0FF, 12'hF0F, 12'h888, 12'hDB9,
    12'h444, 12'hC60, 12'h6CF, 12'hA52
  };

  function automatic rgb_t default_entry(input logic [DEF_IDX_W-1:0] idx);
    return rgb_t'(DEFAULT_PALETTE[idx]);
  endfunction

endpackage

// File: rtl/palette_ram.sv
// Simple dual-port palette storage: one write port, one registered read port.
// Read-during-write to the same address returns the old word; the caller bypasses.
module palette_ram #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write commit and synchronous read.
  always_ff @(posedge Clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sprite_palette_lut.sv
// Multi-bank runtime-writable colour lookup with default-palette init,
// two-stage lookup pipeline, transparency flag and brightness dimming.
module sprite_palette_lut
  import sprite_palette_pkg::*;
#(
  parameter int unsigned INDEX_W    = 4,
  parameter int unsigned COLOR_W    = 4,
  parameter int unsigned NUM_PAL    = 4,
  parameter int unsigned TRANSP_IDX = 0,
  localparam int unsigned PAL_W     = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 pix_valid,
  input  logic [PAL_W-1:0]     pix_pal,
  input  logic [INDEX_W-1:0]   pix_index,
  input  logic [1:0]           dim_shift,
  input  logic                 wr_en,
  input  logic [PAL_W-1:0]     wr_pal,
  input  logic [INDEX_W-1:0]   wr_index,
  input  logic [3*COLOR_W-1:0] wr_rgb,
  output logic                 wr_ack,
  output logic                 init_busy,
  output logic                 out_valid,
  output logic                 out_transp,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue
);

  localparam int unsigned ADDR_W  = PAL_W + INDEX_W;
  localparam int unsigned RGB_W   = 3 * COLOR_W;
  localparam int unsigned NUM_ENT = NUM_PAL << INDEX_W;

  pal_state_e        state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;

  // Init walks banks b-major/i-minor, which is exactly the linear {bank,index} address.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == ADDR_W'(NUM_ENT - 1)) begin
        state_d = RUN;
      end
    end
  end

  // FSM and init counter state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign init_busy = (state_q == INIT);

  // Write port arbitration: init loader owns the RAM until RUN.
  rgb_t              def_ent;
  logic [RGB_W-1:0]  init_wdata;
  logic              wr_pal_ok, pix_pal_ok, user_commit;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [RGB_W-1:0]  ram_wdata, ram_rdata;
  logic [PAL_W-1:0]  rd_bank;

  assign def_ent    = default_entry(DEF_IDX_W'(init_cnt_q[INDEX_W-1:0]));
  assign init_wdata = {COLOR_W'(def_ent.r), COLOR_W'(def_ent.g), COLOR_W'(def_ent.b)};

  // Select write source and sanitise bank numbers.
  always_comb begin
    wr_pal_ok   = 32'(wr_pal) < NUM_PAL;
    pix_pal_ok  = 32'(pix_pal) < NUM_PAL;
    user_commit = !Reset && (state_q == RUN) && wr_en && wr_pal_ok;
    ram_we      = (state_q == INIT) || user_commit;
    ram_waddr   = (state_q == INIT) ? init_cnt_q : {wr_pal, wr_index};
    ram_wdata   = (state_q == INIT) ? init_wdata : wr_rgb;
    rd_bank     = pix_pal_ok ? pix_pal : '0;
    ram_raddr   = {rd_bank, pix_index};
  end

  palette_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(RGB_W),
    .DEPTH (NUM_ENT)
  ) u_ram (
    .Clk  (Clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  // Write acknowledge pulse, one cycle after the commit edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= user_commit;
    end
  end

  // Stage 1: request side-band plus write-through bypass capture.
  logic               s1_valid_q, s1_init_q, byp_hit_q;
  logic [INDEX_W-1:0] s1_index_q;
  logic [1:0]         s1_dim_q;
  logic [RGB_W-1:0]   byp_data_q;

  // Stage 1 registers alongside the RAM read.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      s1_init_q  <= 1'b0;
      s1_index_q <= '0;
      s1_dim_q   <= '0;
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      s1_valid_q <= pix_valid;
      s1_init_q  <= (state_q == INIT);
      s1_index_q <= pix_index;
      s1_dim_q   <= dim_shift;
      byp_hit_q  <= ram_we && (ram_waddr == ram_raddr);
      byp_data_q <= ram_wdata;
    end
  end

  // Stage 2 next-state: pick RAM or bypass data, dim, apply init/idle forcing.
  logic [RGB_W-1:0]   s2_src;
  logic [COLOR_W-1:0] red_d, green_d, blue_d;
  logic               transp_d;

  always_comb begin
    s2_src   = byp_hit_q ? byp_data_q : ram_rdata;
    red_d    = '0;
    green_d  = '0;
    blue_d   = '0;
    transp_d = 1'b0;
    if (s1_valid_q) begin
      if (s1_init_q) begin
        transp_d = 1'b1;
      end else begin
        red_d    = s2_src[3*COLOR_W-1:2*COLOR_W] >> s1_dim_q;
        green_d  = s2_src[2*COLOR_W-1:COLOR_W] >> s1_dim_q;
        blue_d   = s2_src[COLOR_W-1:0] >> s1_dim_q;
        transp_d = (s1_index_q == INDEX_W'(TRANSP_IDX));
      end
    end
  end

  // Stage 2 output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid  <= 1'b0;
      out_transp <= 1'b0;
      red        <= '0;
      green      <= '0;
      blue       <= '0;
    end else begin
      out_valid  <= s1_valid_q;
      out_transp <= transp_d;
      red        <= red_d;
      green      <= green_d;
      blue       <= blue_d;
    end
  end

endmodule

// File: tb/tb_sprite_palette_lut.sv
// Self-checking bench for sprite_palette_lut: array-based palette model,
// expected outputs predicted per request and compared two cycles later.
module tb_sprite_palette_lut;

  localparam int unsigned NUM_PAL    = 4;
  localparam int unsigned ENTRIES    = 16;
  localparam int unsigned INIT_LEN   = NUM_PAL * ENTRIES;
  localparam logic [3:0]  TRANSP_IDX = 4'd0;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        pix_valid = 1'b0;
  logic [1:0]  pix_pal = '0;
  logic [3:0]  pix_index = '0;
  logic [1:0]  dim_shift = '0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_pal = '0;
  logic [3:0]  wr_index = '0;
  logic [11:0] wr_rgb = '0;
  logic        wr_ack, init_busy, out_valid, out_transp;
  logic [3:0]  red, green, blue;

  always #5 Clk = ~Clk;

  sprite_palette_lut dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .pix_valid (pix_valid),
    .pix_pal   (pix_pal),
    .pix_index (pix_index),
    .dim_shift (dim_shift),
    .wr_en     (wr_en),
    .wr_pal    (wr_pal),
    .wr_index  (wr_index),
    .wr_rgb    (wr_rgb),
    .wr_ack    (wr_ack),
    .init_busy (init_busy),
    .out_valid (out_valid),
    .out_transp(out_transp),
    .red       (red),
    .green     (green),
    .blue      (blue)
  );

  // Reference data.
  logic [11:0] def_pal [ENTRIES] = '{
    12'h000, 12'hFFF, 12'hF00, 12'h630, 12'h0F0, 12'h00F, 12'h084, 12'hFF0,
    12'h0FF, 12'hF0F, 12'h888, 12'hDB9, 12'h444, 12'hC60, 12'h6CF, 12'hA52
  };
  logic [11:0] model [NUM_PAL][ENTRIES];
  int          init_left;
  logic [13:0] exp_cur, exp_prev;   // {valid, transp, rgb}
  logic        exp_ack;
  int          n_checks = 0;
  int          n_fail = 0;

  wire [14:0] obs = {out_valid, out_transp, red, green, blue, wr_ack};

  function automatic logic [3:0] dimmed(input logic [3:0] c, input logic [1:0] d);
    return 4'(int'(c) / (1 << d));
  endfunction

  // Present one cycle of stimulus; predict its output; advance to the next negedge.
  task automatic drive(input logic v, input logic [1:0] pal, input logic [3:0] idx,
                       input logic [1:0] dim, input logic we, input logic [1:0] wpal,
                       input logic [3:0] widx, input logic [11:0] wrgb);
    logic        busy, commit;
    logic [11:0] c;
    busy      = init_left > 0;
    pix_valid = v;
    pix_pal   = pal;
    pix_index = idx;
    dim_shift = dim;
    wr_en     = we;
    wr_pal    = wpal;
    wr_index  = widx;
    wr_rgb    = wrgb;
    commit = we && !busy && (int'(wpal) < NUM_PAL);
    if (commit) model[wpal][widx] = wrgb;
    c = model[(int'(pal) < NUM_PAL) ? pal : 2'd0][idx];
    exp_prev = exp_cur;
    if (!v)        exp_cur = '0;
    else if (busy) exp_cur = {2'b11, 12'h000};
    else exp_cur = {1'b1, idx == TRANSP_IDX,
                    dimmed(c[11:8], dim), dimmed(c[7:4], dim), dimmed(c[3:0], dim)};
    exp_ack = commit;
    @(posedge Clk);
    if (init_left > 0) init_left--;
    @(negedge Clk);
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 2'd0, 4'd0, 12'h000);
  endtask

  task automatic apply_reset(input int cycles);
    Reset = 1'b1;
    pix_valid = 1'b0;
    wr_en = 1'b0;
    repeat (cycles) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    for (int b = 0; b < NUM_PAL; b++)
      for (int i = 0; i < ENTRIES; i++) model[b][i] = def_pal[i];
    init_left = INIT_LEN;
    exp_cur  = '0;
    exp_prev = '0;
    exp_ack  = 1'b0;
  endtask

  task automatic test_reset();
    int busy_cycles = 0;
    int ack_seen = 0;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    n_checks++;
    if ({obs, init_busy} !== {15'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", {obs, init_busy}, {15'h0, 1'b1});
    end
    apply_reset(1);
    for (int k = 0; k < 200 && init_busy === 1'b1; k++) begin
      busy_cycles++;
      drive(1'($urandom), 2'($urandom), 4'($urandom), 2'($urandom),
            1'($urandom), 2'($urandom), 4'($urandom), 12'($urandom));
      n_checks++;
      if (obs !== {exp_prev, exp_ack}) begin
        n_fail++;
        $display("FAIL init_lookup: got %h expected %h", obs, {exp_prev, exp_ack});
      end
      if (wr_ack === 1'b1) ack_seen++;
    end
    n_checks++;
    if (busy_cycles != INIT_LEN) begin
      n_fail++;
      $display("FAIL init_busy_len: got %0d expected %0d", busy_cycles, INIT_LEN);
    end
    n_checks++;
    if (ack_seen != 0) begin
      n_fail++;
      $display("FAIL init_no_ack: got %0d acks expected 0", ack_seen);
    end
  endtask

  task automatic test_default_lookup();
    drive(1'b1, 2'd2, 4'd3, 2'd0, 1'b0, 2'd0, 4'd0, 12'h000);
    idle();
    n_checks++;
    if (obs !== {2'b10, 12'h630, 1'b0} || obs !== {exp_prev, exp_ack}) begin
      n_fail++;
      $display("FAIL default_b2_i3: got %h expected %h", obs, {2'b10, 12'h630, 1'b0});
    end
  endtask

  task automatic test_write_dim();
    drive(1'b0, 2'd0, 4'd0, 2'd0, 1'b1, 2'd1, 4'd6, 12'hF0A);
    n_checks++;
    if (wr_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL write_ack: got %b expected 1", wr_ack);
    end
    drive(1'b1, 2'd1, 4'd6, 2'd1, 1'b0, 2'd0, 4'd0, 12'h000);
    n_checks++;
    if (wr_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_single_pulse: got %b expected 0", wr_ack);
    end
    drive(1'b1, 2'd0, 4'd6, 2'd0, 1'b0, 2'd0, 4'd0, 12'h000);
    n_checks++;
    if (obs !== {2'b10, 12'h705, 1'b0} || obs !== {exp_prev, exp_ack}) begin
      n_fail++;
      $display("FAIL write_dim_b1_i6: got %h expected %h", obs, {2'b10, 12'h705, 1'b0});
    end
    idle();
    n_checks++;
    if (obs !== {2'b10, 12'h084, 1'b0} || obs !== {exp_prev, exp_ack}) begin
      n_fail++;
      $display("FAIL bank0_untouched: got %h expected %h", obs, {2'b10, 12'h084, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    int beats = 0;
    int transp_beats = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < ENTRIES)
        drive(1'b1, 2'($urandom), 4'(i), 2'($urandom), 1'b0, 2'd0, 4'd0, 12'h000);
      else
        idle();
      if (i > 0) begin
        n_checks++;
        if (obs !== {exp_prev, exp_ack}) begin
          n_fail++;
          $display("FAIL b2b_beat%0d: got %h expected %h", i - 1, obs, {exp_prev, exp_ack});
        end
        if (out_valid === 1'b1) beats++;
        if (out_transp === 1'b1) transp_beats++;
      end
    end
    n_checks++;
    if (beats != ENTRIES || transp_beats != 1) begin
      n_fail++;
      $display("FAIL b2b_counts: got %0d beats %0d transp expected 16 beats 1 transp",
               beats, transp_beats);
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 2'd0, 4'd11, 2'd0, 1'b1, 2'd0, 4'd11, 12'h123);
    idle();
    n_checks++;
    if (obs !== {2'b10, 12'h123, 1'b0} || obs !== {exp_prev, exp_ack}) begin
      n_fail++;
      $display("FAIL collision_bypass: got %h expected %h", obs, {2'b10, 12'h123, 1'b0});
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom), 2'($urandom), 4'($urandom), 2'($urandom),
            ($urandom_range(0, 9) < 3), 2'($urandom), 4'($urandom), 12'($urandom));
      n_checks++;
      if ({obs, init_busy} !== {exp_prev, exp_ack, init_left > 0}) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h expected %h", k, {obs, init_busy},
                 {exp_prev, exp_ack, init_left > 0});
      end
    end
  endtask

  task automatic test_reset_mid_init();
    int busy_cycles = 0;
    apply_reset(2);
    repeat (30) idle();
    apply_reset(1);
    for (int k = 0; k < 200 && init_busy === 1'b1; k++) begin
      busy_cycles++;
      idle();
    end
    n_checks++;
    if (busy_cycles != INIT_LEN) begin
      n_fail++;
      $display("FAIL restart_busy_len: got %0d expected %0d", busy_cycles, INIT_LEN);
    end
    for (int a = 0; a <= INIT_LEN; a++) begin
      if (a < INIT_LEN)
        drive(1'b1, 2'(a / ENTRIES), 4'(a % ENTRIES), 2'd0, 1'b0, 2'd0, 4'd0, 12'h000);
      else
        idle();
      if (a > 0) begin
        n_checks++;
        if (obs !== {exp_prev, exp_ack}) begin
          n_fail++;
          $display("FAIL restart_default%0d: got %h expected %h", a - 1, obs,
                   {exp_prev, exp_ack});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_lookup();
    test_write_dim();
    test_back_to_back();
    test_collision();
    test_random();
    test_reset_mid_init();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
